// File: rtl/csa_accum_stage.sv
// Carry-save accumulation stage: folds a stream of N-bit operands into a W-bit
// redundant sum/carry pair with a 3:2 compressor, one operand per cycle.
module csa_accum_stage #(
   parameter int unsigned N = 16,
   parameter int unsigned W = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_s,
   output logic [W-1:0] out_c,
   output logic [7:0]   out_count,
   output logic         busy
);

   localparam int unsigned CNT_W = 8;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] ACC  = 2'b01;
   localparam logic [1:0] OUT  = 2'b10;

   logic [1:0]       state, state_nxt;
   logic [W-1:0]     s_q, c_q, s_nxt, c_nxt;
   logic [W-1:0]     x, maj;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             accept;

   assign in_ready = (state != OUT) && !flush;
   assign accept   = in_valid && in_ready;

   // 3:2 compressor over the running sum, running carry and new operand
   assign x   = W'(in_data);
   assign maj = (s_q & c_q) | (s_q & x) | (c_q & x);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         s_q   <= '0;
         c_q   <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         s_q   <= s_nxt;
         c_q   <= c_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   // Next state and datapath; flush overrides both accept and output handshake
   always_comb begin
      state_nxt = state;
      s_nxt     = s_q;
      c_nxt     = c_q;
      cnt_nxt   = cnt_q;
      if (flush) begin
         state_nxt = IDLE;
         s_nxt     = '0;
         c_nxt     = '0;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE, ACC: begin
               if (accept) begin
                  s_nxt     = s_q ^ c_q ^ x;
                  c_nxt     = maj << 1;
                  cnt_nxt   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                  state_nxt = in_last ? OUT : ACC;
               end
            end
            OUT: begin
               if (out_ready) begin
                  state_nxt = IDLE;
                  s_nxt     = '0;
                  c_nxt     = '0;
                  cnt_nxt   = '0;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);
   assign out_s     = s_q;
   assign out_c     = c_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_csa_accum_stage.sv
// Directed bench for csa_accum_stage with a queue-based scoreboard of batch results.
module tb_csa_accum_stage;

   localparam int unsigned N = 16;
   localparam int unsigned W = 20;

   typedef struct packed {
      logic [W-1:0] sum;
      logic [7:0]   cnt;
   } exp_t;

   logic         clk, rst_n, flush, in_valid, in_ready, in_last;
   logic [N-1:0] in_data;
   logic         out_valid, out_ready, busy;
   logic [W-1:0] out_s, out_c;
   logic [7:0]   out_count;

   int           checks = 0;
   int           errors = 0;
   exp_t         sb[$];
   logic [W-1:0] model_sum;
   int           model_cnt;

   csa_accum_stage #(.N(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s(out_s), .out_c(out_c), .out_count(out_count), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      model_sum = '0;
      model_cnt = 0;
   endtask

   // One accepted beat; consecutive calls give back-to-back beats
   task automatic beat(input logic [N-1:0] d, input logic last);
      exp_t e;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      model_sum = model_sum + W'(d);
      if (model_cnt < 255) model_cnt++;
      if (last) begin
         e.sum = model_sum;
         e.cnt = 8'(model_cnt);
         sb.push_back(e);
         model_clear();
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_busy"},  32'(busy),      32'd0);
      chk({tag, "_s"},     32'(out_s),     32'd0);
      chk({tag, "_c"},     32'(out_c),     32'd0);
      chk({tag, "_cnt"},   32'(out_count), 32'd0);
   endtask

   // Wait for a result, compare it (holding it for 'hold' cycles), then hand it off
   task automatic collect(input string tag, input int hold);
      int           k;
      exp_t         e;
      logic [W-1:0] r;
      k = 0;
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
      chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
      else e = '0;
      for (int i = 0; i <= hold; i++) begin
         r = out_s + out_c;
         chk({tag, "_sum"},   32'(r),         32'(e.sum));
         chk({tag, "_cnt"},   32'(out_count), 32'(e.cnt));
         chk({tag, "_c0"},    32'(out_c[0]),  32'd0);
         chk({tag, "_ready"}, 32'(in_ready),  32'd0);
         chk({tag, "_valid"}, 32'(out_valid), 32'd1);
         if (i < hold) @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_idle({tag, "_post"});
   endtask

   initial begin
      exp_t discard;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      out_ready = 1'b0;
      model_clear();
      #12;
      check_idle("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", 32'(in_ready), 32'd1);

      // Single operand: direct IDLE->OUT with S = x, C = 0
      beat(16'h1234, 1'b1);
      chk("single_s", 32'(out_s), 32'h01234);
      chk("single_c", 32'(out_c), 32'h0);
      collect("single", 0);

      // Three-operand batch
      repeat (2) beat(16'hFFFF, 1'b0);
      beat(16'hFFFF, 1'b1);
      collect("three", 0);

      // Wrap-around modulo 2^W
      repeat (16) beat(16'hFFFF, 1'b0);
      beat(16'hFFFF, 1'b1);
      collect("wrap", 0);

      // Count saturation
      repeat (299) beat(16'h0001, 1'b0);
      beat(16'h0001, 1'b1);
      collect("sat", 0);

      // Backpressure, then a new batch the cycle after the handshake
      beat(16'h0001, 1'b0);
      beat(16'h0002, 1'b1);
      collect("bp", 5);
      beat(16'hABCD, 1'b0);
      beat(16'h1111, 1'b1);
      collect("bp_next", 0);

      // Flush colliding with a beat mid-batch
      beat(16'h0010, 1'b0);
      beat(16'h0020, 1'b0);
      flush = 1'b1; in_valid = 1'b1; in_data = 16'h0040; in_last = 1'b1;
      #1;
      chk("flush_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      model_clear();
      check_idle("flush_acc");

      // Flush colliding with the output handshake
      beat(16'h0005, 1'b1);
      chk("flush_out_pre", 32'(out_valid), 32'd1);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0; out_ready = 1'b0;
      discard = sb.pop_front();
      check_idle("flush_out");
      @(posedge clk);
      #1;
      chk("flush_out_again", 32'(out_valid), 32'd0);
      beat(16'h0007, 1'b1);
      collect("after_flush", 0);

      // Asynchronous reset mid-batch
      beat(16'h0100, 1'b0);
      beat(16'h0200, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("async_rst");
      #2;
      rst_n = 1'b1;
      model_clear();
      beat(16'h0003, 1'b0);
      beat(16'h0004, 1'b1);
      collect("after_rst", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
